// File: rtl/fingerprint_player.sv
// rtl/fingerprint_player.sv - streams the stored fingerprint waveform with DC offset, repeats and gaps
module fingerprint_player #(
    parameter int SAMPLE_DATA_WIDTH = 8,
    parameter int CAPTURE_LENGTH = 1000,
    parameter FINGERPRINT_MEMORY_FILE = "",
    parameter int GAP_WIDTH = 16,
    parameter logic [CAPTURE_LENGTH*SAMPLE_DATA_WIDTH-1:0] ROM_INIT = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic [7:0]                   repeat_count,
    input  logic [GAP_WIDTH-1:0]         gap_cycles,
    input  logic [SAMPLE_DATA_WIDTH-1:0] dc_offset,
    input  logic                         axior,
    output logic                         axiov,
    output logic [SAMPLE_DATA_WIDTH-1:0] axiod,
    output logic                         axiol,
    output logic                         busy,
    output logic                         done
);
    localparam int W  = SAMPLE_DATA_WIDTH;
    localparam int L  = CAPTURE_LENGTH;
    localparam int AW = (L > 1) ? $clog2(L) : 1;
    localparam int CW = $clog2(L + 1);

    typedef enum logic [1:0] {IDLE, STREAM, GAP, DONE} state_t;
    state_t state, state_next;

    logic [7:0]           repeats_q;
    logic [7:0]           bursts_q;
    logic [GAP_WIDTH-1:0] gap_q;
    logic [GAP_WIDTH-1:0] gap_cnt_q;
    logic [W-1:0]         offset_q;
    logic [CW-1:0]        addr_q;

    logic          s1_v, s1_last, s2_v, s2_last;
    logic [AW-1:0] s1_addr;
    logic [W-1:0]  rom_q;

    logic [W-1:0] fifo_data [4];
    logic         fifo_last [4];
    logic [1:0]   wr_ptr, rd_ptr;
    logic [2:0]   fifo_count;
    logic [2:0]   in_flight;

    logic         xfer, last_xfer, rd_issue, flush, accept, final_burst;
    logic [W:0]   sum;
    logic [W-1:0] sat_sum;

    assign in_flight   = {2'b00, s1_v} + {2'b00, s2_v};
    assign axiov       = (state == STREAM) && (fifo_count != 3'd0);
    assign axiod       = axiov ? fifo_data[rd_ptr] : '0;
    assign axiol       = axiov && fifo_last[rd_ptr];
    assign busy        = (state == STREAM) || (state == GAP);
    assign done        = (state == DONE);
    assign xfer        = axiov && axior;
    assign last_xfer   = xfer && fifo_last[rd_ptr];
    assign flush       = abort && (state != IDLE);
    assign accept      = (state == IDLE) && start && !abort;
    assign final_burst = ({1'b0, bursts_q} + 9'd1) == {1'b0, repeats_q};
    // Reads are throttled so FIFO contents plus reads still in the ROM pipe never exceed 4.
    assign rd_issue    = (state == STREAM) && (addr_q < CW'(L)) && ((fifo_count + in_flight) < 3'd4);

    // Sign-extend both operands one bit so overflow is visible in the top two bits.
    always_comb begin
        sum = {rom_q[W-1], rom_q} + {offset_q[W-1], offset_q};
        sat_sum = sum[W-1:0];
        if (sum[W] != sum[W-1]) begin
            sat_sum = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (accept) state_next = STREAM;
            STREAM: begin
                if (last_xfer) begin
                    if (final_burst)                  state_next = DONE;
                    else if (gap_q == '0)             state_next = STREAM;
                    else                              state_next = GAP;
                end
            end
            GAP:    if (gap_cnt_q == '0) state_next = STREAM;
            DONE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            repeats_q <= 8'd1;
            bursts_q  <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            offset_q  <= '0;
            addr_q    <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                repeats_q <= (repeat_count == 8'd0) ? 8'd1 : repeat_count;
                gap_q     <= gap_cycles;
                offset_q  <= dc_offset;
                bursts_q  <= '0;
                addr_q    <= '0;
            end
            if (rd_issue) addr_q <= addr_q + CW'(1);
            if (state == GAP) gap_cnt_q <= gap_cnt_q - GAP_WIDTH'(1);
            if (last_xfer) begin
                bursts_q  <= bursts_q + 8'd1;
                addr_q    <= '0;
                gap_cnt_q <= gap_q - GAP_WIDTH'(1);
            end
            if (flush) addr_q <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v       <= 1'b0;
            s1_last    <= 1'b0;
            s1_addr    <= '0;
            s2_v       <= 1'b0;
            s2_last    <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (flush) begin
            s1_v       <= 1'b0;
            s2_v       <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            s1_v       <= rd_issue;
            s1_last    <= (addr_q == CW'(L - 1));
            s1_addr    <= addr_q[AW-1:0];
            s2_v       <= s1_v;
            s2_last    <= s1_last;
            if (s2_v) wr_ptr <= wr_ptr + 2'd1;
            if (xfer) rd_ptr <= rd_ptr + 2'd1;
            fifo_count <= fifo_count + {2'b00, s2_v} - {2'b00, xfer};
        end
    end

    always_ff @(posedge clk) begin
        if (s2_v) begin
            fifo_data[wr_ptr] <= sat_sum;
            fifo_last[wr_ptr] <= s2_last;
        end
    end

    // Block RAM with registered address and registered output: two cycles read latency.
    always_ff @(posedge clk) rom_q <= ROM_INIT[int'(s1_addr)*W +: W];
endmodule
